// File: rtl/data_memory_pipelined.sv
// data_memory_pipelined: multi-cycle RV32 data memory with configurable latency
//   clk        : sole clock, rising edge
//   reset      : synchronous active-high reset
//   mem_read   : load request, held until done
//   mem_write  : store request, held until done; takes priority over mem_read
//   funct3     : RV32 access type (B/H/W/BU/HU)
//   address    : byte address, little-endian; aliases modulo 4*2^ADDR_BITS
//   data_in    : store data (low byte/half used for B/H)
//   data_out   : load result, valid with done; holds otherwise
//   busy       : high while an access is in flight (state != IDLE)
//   done       : one-cycle completion pulse
//   misaligned : valid with done; access was rejected (misaligned or illegal)
module data_memory_pipelined #(
    parameter int ADDR_BITS = 10,
    parameter int LATENCY   = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] address,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        busy,
    output logic        done,
    output logic        misaligned
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t                 state, state_next;
    logic [3:0]             cnt;
    logic [ADDR_BITS+1:0]   addr_q;
    logic [2:0]             f3_q;
    logic [31:0]            din_q;
    logic                   wr_q;
    logic [31:0]            mem [0:(1<<ADDR_BITS)-1];

    logic                   accept, commit, bad;
    logic [ADDR_BITS-1:0]   idx;
    logic [1:0]             lane;
    logic [31:0]            rword, load_val, wmask, wdata;
    logic [7:0]             rbyte;
    logic [15:0]            rhalf;
    logic                   unused_addr_hi;

    // Upper address bits only alias; they never reach the array.
    assign unused_addr_hi = ^address[31:ADDR_BITS+2];

    assign accept = (state == IDLE) && (mem_read || mem_write);
    assign commit = (state == ACCESS) && (cnt == 4'd0);
    assign busy   = (state != IDLE);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = (mem_read || mem_write) ? ACCESS : IDLE;
            ACCESS:  state_next = (cnt == 4'd0) ? RESP : ACCESS;
            default: state_next = IDLE;
        endcase
    end

    assign idx   = addr_q[ADDR_BITS+1:2];
    assign lane  = addr_q[1:0];
    assign rword = mem[idx];
    assign rbyte = rword[{lane, 3'b000} +: 8];
    assign rhalf = rword[{lane[1], 4'b0000} +: 16];

    // BU/HU are load-only encodings, so a store using them is rejected.
    always_comb begin
        bad = 1'b1;
        case (f3_q)
            3'b000:  bad = 1'b0;
            3'b001:  bad = lane[0];
            3'b010:  bad = |lane;
            3'b100:  bad = wr_q;
            3'b101:  bad = wr_q | lane[0];
            default: bad = 1'b1;
        endcase
    end

    // funct3[2] selects zero extension for BU/HU.
    assign load_val = f3_q[1] ? rword :
                      f3_q[0] ? {{16{~f3_q[2] & rhalf[15]}}, rhalf} :
                                {{24{~f3_q[2] & rbyte[7]}}, rbyte};

    assign wmask = (f3_q == 3'b000) ? (32'h0000_00FF << {lane, 3'b000}) :
                   (f3_q == 3'b001) ? (32'h0000_FFFF << {lane[1], 4'b0000}) :
                                      32'hFFFF_FFFF;
    assign wdata = (f3_q == 3'b000) ? {4{din_q[7:0]}} :
                   (f3_q == 3'b001) ? {2{din_q[15:0]}} : din_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            done       <= 1'b0;
            misaligned <= 1'b0;
            data_out   <= 32'd0;
        end else begin
            state <= state_next;
            done  <= commit;
            if (accept)
                cnt <= 4'(LATENCY - 1);
            else if (state == ACCESS && cnt != 4'd0)
                cnt <= cnt - 4'd1;
            if (commit) begin
                misaligned <= bad;
                data_out   <= (bad || wr_q) ? 32'd0 : load_val;
            end
        end
    end

    // Captured request; don't-care outside an access, so no reset needed.
    always_ff @(posedge clk) begin
        if (accept) begin
            addr_q <= address[ADDR_BITS+1:0];
            f3_q   <= funct3;
            din_q  <= data_in;
            wr_q   <= mem_write;
        end
    end

    // Reset on the commit edge aborts the write.
    always_ff @(posedge clk) begin
        if (commit && !reset && wr_q && !bad)
            mem[idx] <= (rword & ~wmask) | (wdata & wmask);
    end
endmodule

// File: tb/tb_data_memory_pipelined.sv
// tb_data_memory_pipelined: directed self-checking bench for data_memory_pipelined
module tb_data_memory_pipelined;
    logic        clk = 1'b0;
    logic        reset, mem_read, mem_write, busy, done, misaligned;
    logic [2:0]  funct3;
    logic [31:0] address, data_in, data_out;
    int          ncmp = 0;
    int          nerr = 0;

    data_memory_pipelined #(.ADDR_BITS(10), .LATENCY(2)) dut (
        .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
        .funct3(funct3), .address(address), .data_in(data_in),
        .data_out(data_out), .busy(busy), .done(done), .misaligned(misaligned)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] din;
        logic [31:0] ed;
        logic        em;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic acc(input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] din,
                       output logic [31:0] d, output logic m);
        int n;
        mem_read = rd; mem_write = wr; funct3 = f3; address = a; data_in = din;
        n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (!done && n < 40);
        mem_read = 1'b0; mem_write = 1'b0;
        if (!done) begin
            ncmp++; nerr++;
            $display("FAIL timeout: no done for addr %h after %0d cycles", a, n);
        end
        d = data_out; m = misaligned;
    endtask

    initial begin
        vec_t        tbl[24];
        logic [31:0] d;
        logic        m;
        logic [3:0]  eb, ed;
        int          npulse;

        tbl[0]  = '{1'b1, 1'b0, 3'd2, 32'h0C,   32'h0,        32'hDEADBEEF, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, 3'd2, 32'h10,   32'h11223344, 32'h0,        1'b0};
        tbl[2]  = '{1'b0, 1'b1, 3'd0, 32'h11,   32'h123456AA, 32'h0,        1'b0};
        tbl[3]  = '{1'b0, 1'b1, 3'd1, 32'h12,   32'h9999BEEF, 32'h0,        1'b0};
        tbl[4]  = '{1'b1, 1'b0, 3'd2, 32'h10,   32'h0,        32'hBEEFAA44, 1'b0};
        tbl[5]  = '{1'b1, 1'b0, 3'd0, 32'h11,   32'h0,        32'hFFFFFFAA, 1'b0};
        tbl[6]  = '{1'b1, 1'b0, 3'd4, 32'h11,   32'h0,        32'h000000AA, 1'b0};
        tbl[7]  = '{1'b1, 1'b0, 3'd1, 32'h12,   32'h0,        32'hFFFFBEEF, 1'b0};
        tbl[8]  = '{1'b1, 1'b0, 3'd5, 32'h12,   32'h0,        32'h0000BEEF, 1'b0};
        tbl[9]  = '{1'b1, 1'b0, 3'd0, 32'h10,   32'h0,        32'h00000044, 1'b0};
        tbl[10] = '{1'b1, 1'b0, 3'd1, 32'h10,   32'h0,        32'hFFFFAA44, 1'b0};
        tbl[11] = '{1'b0, 1'b1, 3'd2, 32'h0E,   32'h12345678, 32'h0,        1'b1};
        tbl[12] = '{1'b1, 1'b0, 3'd2, 32'h0C,   32'h0,        32'hDEADBEEF, 1'b0};
        tbl[13] = '{1'b1, 1'b0, 3'd1, 32'h03,   32'h0,        32'h0,        1'b1};
        tbl[14] = '{1'b1, 1'b0, 3'd3, 32'h00,   32'h0,        32'h0,        1'b1};
        tbl[15] = '{1'b0, 1'b1, 3'd4, 32'h10,   32'hFF,       32'h0,        1'b1};
        tbl[16] = '{1'b1, 1'b0, 3'd2, 32'h10,   32'h0,        32'hBEEFAA44, 1'b0};
        tbl[17] = '{1'b0, 1'b1, 3'd1, 32'h13,   32'h7777,     32'h0,        1'b1};
        tbl[18] = '{1'b0, 1'b1, 3'd2, 32'h1000, 32'hA5A5A5A5, 32'h0,        1'b0};
        tbl[19] = '{1'b1, 1'b0, 3'd2, 32'h0000, 32'h0,        32'hA5A5A5A5, 1'b0};
        tbl[20] = '{1'b1, 1'b0, 3'd5, 32'h1002, 32'h0,        32'h0000A5A5, 1'b0};
        tbl[21] = '{1'b1, 1'b0, 3'd2, 32'h11,   32'h0,        32'h0,        1'b1};
        tbl[22] = '{1'b1, 1'b1, 3'd0, 32'h10,   32'h5A,       32'h0,        1'b0};
        tbl[23] = '{1'b1, 1'b0, 3'd2, 32'h10,   32'h0,        32'hBEEFAA5A, 1'b0};

        reset = 1'b1; mem_read = 1'b0; mem_write = 1'b0;
        funct3 = 3'd0; address = 32'd0; data_in = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_mis", {31'd0, misaligned}, 32'd0);
        chk("rst_data", data_out, 32'd0);
        reset = 1'b0;

        eb = 4'b0111; ed = 4'b0100;
        mem_write = 1'b1; funct3 = 3'd2; address = 32'h0C; data_in = 32'hDEADBEEF;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk($sformatf("tim_busy_E%0d", i), {31'd0, busy}, {31'd0, eb[i]});
            chk($sformatf("tim_done_E%0d", i), {31'd0, done}, {31'd0, ed[i]});
            if (i == 2) mem_write = 1'b0;
        end

        for (int i = 0; i < 24; i++) begin
            acc(tbl[i].rd, tbl[i].wr, tbl[i].f3, tbl[i].a, tbl[i].din, d, m);
            chk($sformatf("vec%0d_data", i), d, tbl[i].ed);
            chk($sformatf("vec%0d_mis", i), {31'd0, m}, {31'd0, tbl[i].em});
        end

        // Request held through the RESP edge must not be accepted again.
        @(posedge clk); #1;
        mem_write = 1'b1; funct3 = 3'd2; address = 32'h20; data_in = 32'h77;
        npulse = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (done) npulse++;
        end
        mem_write = 1'b0;
        chk("hold_busy_after_resp", {31'd0, busy}, 32'd0);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (done) npulse++;
        end
        chk("hold_done_count", npulse, 1);

        // Reset sampled at E1 and at the commit edge E2 both abort the store.
        for (int k = 1; k <= 2; k++) begin
            @(posedge clk); #1;
            mem_write = 1'b1; funct3 = 3'd2; address = 32'h20; data_in = 32'h55;
            @(posedge clk); #1;
            if (k == 2) begin
                @(posedge clk); #1;
            end
            reset = 1'b1;
            @(posedge clk); #1;
            reset = 1'b0; mem_write = 1'b0;
            chk($sformatf("abort%0d_busy", k), {31'd0, busy}, 32'd0);
            npulse = 0;
            for (int i = 0; i < 5; i++) begin
                @(posedge clk); #1;
                if (done) npulse++;
            end
            chk($sformatf("abort%0d_no_done", k), npulse, 0);
            acc(1'b1, 1'b0, 3'd2, 32'h20, 32'h0, d, m);
            chk($sformatf("abort%0d_mem", k), d, 32'h77);
        end

        // Reset with a store request held: outputs clear and nothing is written.
        acc(1'b1, 1'b0, 3'd1, 32'h03, 32'h0, d, m);
        reset = 1'b1; mem_write = 1'b1; funct3 = 3'd2; address = 32'h0; data_in = 32'hFFFFFFFF;
        repeat (2) @(posedge clk);
        #1;
        chk("rst2_busy", {31'd0, busy}, 32'd0);
        chk("rst2_done", {31'd0, done}, 32'd0);
        chk("rst2_mis", {31'd0, misaligned}, 32'd0);
        chk("rst2_data", data_out, 32'd0);
        reset = 1'b0; mem_write = 1'b0;
        acc(1'b1, 1'b0, 3'd2, 32'h0, 32'h0, d, m);
        chk("rst2_mem", d, 32'hA5A5A5A5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule

// File: doc/data_memory_pipelined.md
# data_memory_pipelined

Parametrised, multi-cycle data memory for the MEM stage of the RV32IM pipeline, replacing the single-cycle byte/half/word data memory. It accepts one load or store at a time over a hold-until-done handshake and applies a configurable access latency. Load results are sign- or zero-extended per RV32 `funct3`, and store data is byte-lane merged. Misaligned accesses are flagged, and memory is left unmodified.

## Interface
Parameters:
- `ADDR_BITS`, default 10: log2 of the word count; memory is 2^ADDR_BITS 32-bit words (4 KiB by default).
- `LATENCY`, default 2: number of clock edges from accept to commit; legal range 1..15.

Ports:
- `clk`  in  1  sole clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `mem_read`  in  1  load request; held stable by requester until `done`.
- `mem_write`  in  1  store request; held until `done`; wins if both are high.
- `funct3`  in  3  access type: 000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU are loads only).
- `address`  in  32  byte address, little-endian.
- `data_in`  in  32  store data; the low byte or half is used for B/H.
- `data_out`  out  32  load result, valid while `done`=1; otherwise holds its last value.
- `busy`  out  1  high while state ≠ IDLE.
- `done`  out  1  one-cycle completion pulse.
- `misaligned`  out  1  valid with `done`; the access was rejected.

## Operation
- **Word index:** `address[ADDR_BITS+1:2]`. Upper address bits are ignored, so addresses alias modulo 4·2^ADDR_BITS.
- **States:**
  - IDLE → ACCESS: on an edge with `mem_read|mem_write`=1. At that edge `address`, `funct3`, `data_in` and the op are captured; later input changes are ignored. The counter is loaded with LATENCY-1.
  - ACCESS with counter≠0 → ACCESS: counter decrements.
  - ACCESS with counter=0 → RESP (the commit edge): the access is performed, `done`←1, `data_out`/`misaligned` are updated.
  - RESP → IDLE: unconditional; requests seen during RESP are ignored. This prevents re-accepting a request the requester is still holding.
- **Alignment:**
  - H/HU with `address[0]`=1 is misaligned.
  - W with `address[1:0]`≠0 is misaligned.
  - B is never misaligned.
  - On a misaligned access: `misaligned`=1, no memory write, `data_out`=0.
- **Loads:**
  - B: byte lane `address[1:0]`, sign-extended. BU: same lane, zero-extended.
  - H: half lane `address[1]`, sign-extended. HU: same lane, zero-extended.
  - W: full word.
- **Stores:**
  - SB writes only lane `address[1:0]` with `data_in[7:0]`.
  - SH writes lanes {`address[1]`·2, +1} with `data_in[15:0]`.
  - SW writes the whole word.
  - Other lanes are preserved. On store completion `data_out`=0.
- **Illegal funct3** (011, 110, 111, and 100/101 on a store): completes normally with `misaligned`=1, no write, `data_out`=0.
- Memory array contents are not cleared by `reset`; power-up contents are undefined.

## Timing
- Accept edge is E0. The commit happens at edge E(LATENCY), and `done` is high for the cycle after it.
- `busy` is high from after E0 until after E(LATENCY+1). The next request can be sampled at E(LATENCY+2) at the earliest, so throughput is one access per LATENCY+2 cycles.
- A store is visible to a load accepted at any edge after its commit edge.
- **Reset values:** state=IDLE, counter=0, `busy`=0, `done`=0, `misaligned`=0, `data_out`=0.
- **Reset mid-operation:** reset asserted at or before the commit edge aborts the access. No write occurs and no `done` pulse is produced.
- Reset during RESP clears `done` at that edge.
- Request deasserted before `done`: this is a protocol violation, and the captured access still completes.

## Test plan
- **Reset:** hold `reset` 2 cycles with `mem_write`=1 → `busy`/`done`/`misaligned`/`data_out` all 0, and no write occurs (a subsequent LW@0 returns the preloaded value).
- **Word store/load, LATENCY=2:**
  - SW 0xDEADBEEF @0x0C accepted at E0 → `done` high after E2 only, `busy` high for 3 cycles.
  - LW @0x0C → `data_out`=0xDEADBEEF.
- **Lane merge:** SW 0x11223344 @0x10, then SB 0xAA @0x11, then SH 0xBEEF @0x12 → LW @0x10 = 0xBEEFAA44.
- **Extension:** with word @0x10 = 0xBEEFAA44:
  - LB @0x11 = 0xFFFFFFAA; LBU @0x11 = 0x000000AA.
  - LH @0x12 = 0xFFFFBEEF; LHU @0x12 = 0x0000BEEF.
- **Misaligned/illegal:**
  - SW 0x12345678 @0x0E → `misaligned`=1, and LW @0x0C is still 0xDEADBEEF.
  - LH @0x03 → `misaligned`=1, `data_out`=0.
  - funct3=011 → `misaligned`=1.
- **Hold/abort/alias:**
  - Request held through RESP → exactly one `done` per access.
  - Reset at E1 during SW 0x55 @0x20 → LW @0x20 unchanged.
  - With ADDR_BITS=10, SW @0x1000 → readable at @0x0000.
